// File: rtl/pattern_detect_scheduler_if.sv
// Bundle of the per-channel request/grant lines and the hit reporting outputs
// of pattern_detect_scheduler.
interface pattern_detect_scheduler_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(NCH);

    logic             clr;
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   ch_bit;
    logic [NCH-1:0]   ch_ready;
    logic             hit_valid;
    logic [IDX_W-1:0] hit_ch;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output clr,
        output ch_valid,
        output ch_bit,
        input  ch_ready,
        input  hit_valid,
        input  hit_ch,
        input  hit_count
    );

    modport slave (
        input  clr,
        input  ch_valid,
        input  ch_bit,
        output ch_ready,
        output hit_valid,
        output hit_ch,
        output hit_count
    );
endinterface

// File: rtl/pattern_detect_scheduler.sv
// One shared "101" detector time-multiplexed over NCH serial channels by a
// round-robin grant; reports the hitting channel and a saturating hit count.
module pattern_detect_scheduler #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input logic                      clk,
    input logic                      areset,
    pattern_detect_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NCH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StA = 2'd0,
        StB = 2'd1,
        StC = 2'd2,
        StD = 2'd3
    } st_e;

    st_e              st [NCH];
    logic [IDX_W-1:0] ptr;
    logic             hit_valid;
    logic [IDX_W-1:0] hit_ch;
    logic [CNT_W-1:0] hit_count;

    logic [NCH-1:0]   ready;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_found;
    st_e              nxt_st;

    function automatic st_e next_st(input st_e s, input logic b);
        st_e n;
        unique case (s)
            StA:     n = b ? StB : StA;
            StB:     n = b ? StB : StC;
            StC:     n = b ? StD : StA;
            StD:     n = b ? StB : StC;
            default: n = StA;
        endcase
        return n;
    endfunction

    // Cyclic search from ptr; the first valid channel wins.
    always_comb begin
        ready     = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_found && bus.ch_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
        if (bus.clr || areset) gnt_found = 1'b0;
        if (gnt_found) ready[gnt_idx] = 1'b1;
    end

    assign nxt_st = next_st(st[gnt_idx], bus.ch_bit[gnt_idx]);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NCH; i++) st[i] <= StA;
            ptr       <= '0;
            hit_valid <= 1'b0;
            hit_ch    <= '0;
            hit_count <= '0;
        end else if (bus.clr) begin
            // Clear wins over any pending increment; hit_ch keeps its last value.
            for (int i = 0; i < NCH; i++) st[i] <= StA;
            ptr       <= '0;
            hit_valid <= 1'b0;
            hit_count <= '0;
        end else begin
            hit_valid <= 1'b0;
            if (gnt_found) begin
                st[gnt_idx] <= nxt_st;
                ptr         <= (gnt_idx == IDX_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
                if (nxt_st == StD) begin
                    hit_valid <= 1'b1;
                    hit_ch    <= gnt_idx;
                    if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
                end
            end
        end
    end

    assign bus.ch_ready  = ready;
    assign bus.hit_valid = hit_valid;
    assign bus.hit_ch    = hit_ch;
    assign bus.hit_count = hit_count;

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (areset)
        $onehot0(ready));
    a_ready_subset : assert property (@(posedge clk) disable iff (areset)
        (ready & ~bus.ch_valid) == '0);

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// Scoreboard bench: the driver queues hand-computed grants and hits, a negedge
// monitor pops and compares; a CNT_W=2 twin shares the stimulus for saturation.
module tb_pattern_detect_scheduler;
    logic clk = 1'b0;
    logic areset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rdy;
    } gexp_t;

    typedef struct {
        int cyc;
        int ch;
        int cnt;
    } hexp_t;

    gexp_t gq[$];
    hexp_t hq[$];

    pattern_detect_scheduler_if #(.NCH(4), .CNT_W(8)) bus_a ();
    pattern_detect_scheduler_if #(.NCH(4), .CNT_W(2)) bus_s ();

    assign bus_s.clr      = bus_a.clr;
    assign bus_s.ch_valid = bus_a.ch_valid;
    assign bus_s.ch_bit   = bus_a.ch_bit;

    pattern_detect_scheduler #(.NCH(4), .CNT_W(8)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus_a)
    );

    pattern_detect_scheduler #(.NCH(4), .CNT_W(2)) dut_sat (
        .clk    (clk),
        .areset (areset),
        .bus    (bus_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show for it.
    task automatic step(input logic c, input logic [3:0] v, input logic [3:0] b,
                        input logic [3:0] er, input int hch, input int hcnt);
        gexp_t g;
        hexp_t h;
        bus_a.clr      = c;
        bus_a.ch_valid = v;
        bus_a.ch_bit   = b;
        g.cyc = cyc;
        g.rdy = er;
        gq.push_back(g);
        if (hch >= 0) begin
            h.cyc = cyc + 1;
            h.ch  = hch;
            h.cnt = hcnt;
            hq.push_back(h);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},     32'(bus_a.ch_ready),  0);
        check({tag, "_hit_valid"}, 32'(bus_a.hit_valid), 0);
        check({tag, "_hit_ch"},    32'(bus_a.hit_ch),    0);
        check({tag, "_hit_count"}, 32'(bus_a.hit_count), 0);
        check({tag, "_sat_count"}, 32'(bus_s.hit_count), 0);
    endtask

    always @(negedge clk) begin
        gexp_t g;
        hexp_t h;
        if (!areset) begin
            while (gq.size() > 0 && gq[0].cyc < cyc) void'(gq.pop_front());
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                check("ch_ready", 32'(bus_a.ch_ready), 32'(g.rdy));
            end
            if (bus_a.hit_valid) begin
                if (hq.size() == 0) begin
                    check("hit_unexpected", 32'(bus_a.hit_valid), 0);
                end else begin
                    h = hq.pop_front();
                    check("hit_cycle",     32'(cyc),              32'(h.cyc));
                    check("hit_ch",        32'(bus_a.hit_ch),     32'(h.ch));
                    check("hit_count",     32'(bus_a.hit_count),  32'(h.cnt));
                    check("sat_hit_valid", 32'(bus_s.hit_valid),  1);
                    check("sat_hit_count", 32'(bus_s.hit_count),
                          32'((h.cnt > 3) ? 3 : h.cnt));
                end
            end else begin
                while (hq.size() > 0 && hq[0].cyc <= cyc) begin
                    check("hit_missing", 32'(bus_a.hit_valid), 1);
                    void'(hq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [4:0] seq;
        areset         = 1'b1;
        bus_a.clr      = 1'b0;
        bus_a.ch_valid = 4'b1111;
        bus_a.ch_bit   = 4'b0000;
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        check_zero("reset_clk");
        bus_a.ch_valid = 4'b0000;
        #3 areset = 1'b0;
        @(posedge clk);
        #1;

        // Single channel 1,0,1 on ch0.
        step(0, 4'b0001, 4'b0001, 4'b0001, -1, 0);
        step(0, 4'b0001, 4'b0000, 4'b0001, -1, 0);
        step(0, 4'b0001, 4'b0001, 4'b0001,  0, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000, -1, 0);

        // All-valid rotation; ch2 sees 1,0,1 in its slots, others see only 1s.
        step(1, 4'b1111, 4'b0000, 4'b0000, -1, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 4'b1111, (k == 6) ? 4'b1011 : 4'b1111, 4'(1 << (k % 4)),
                 (k == 10) ? 2 : -1, 1);
        end
        step(0, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        check("hold_hit_valid", 32'(bus_a.hit_valid), 0);
        check("hold_hit_ch",    32'(bus_a.hit_ch),    2);
        check("hold_hit_count", 32'(bus_a.hit_count), 1);

        // Overlapping 1,0,1,0,1 on ch1.
        step(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        seq = 5'b10101;
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b0010, {2'b00, seq[4 - k], 1'b0}, 4'b0010,
                 (k == 2 || k == 4) ? 1 : -1, (k == 2) ? 1 : 2);
        end

        // clr in the middle of a pattern.
        step(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        step(0, 4'b0001, 4'b0001, 4'b0001, -1, 0);
        step(0, 4'b0001, 4'b0000, 4'b0001, -1, 0);
        step(1, 4'b0001, 4'b0001, 4'b0000, -1, 0);
        step(0, 4'b0001, 4'b0001, 4'b0001, -1, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        check("clr_hit_count", 32'(bus_a.hit_count), 0);

        // Async reset while a hit is showing and ch3 holds a partial pattern.
        step(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        step(0, 4'b1000, 4'b1000, 4'b1000, -1, 0);
        step(0, 4'b1000, 4'b0000, 4'b1000, -1, 0);
        step(0, 4'b1000, 4'b1000, 4'b1000, -1, 0);
        check("pre_rst_hit_valid", 32'(bus_a.hit_valid), 1);
        check("pre_rst_hit_ch",    32'(bus_a.hit_ch),    3);
        check("pre_rst_hit_count", 32'(bus_a.hit_count), 1);
        bus_a.ch_valid = 4'b1111;
        areset = 1'b1;
        #2;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("async_rst_clk");
        bus_a.ch_valid = 4'b0000;
        #3 areset = 1'b0;
        @(posedge clk);
        #1;
        step(0, 4'b0110, 4'b0000, 4'b0010, -1, 0);
        step(0, 4'b1000, 4'b1000, 4'b1000, -1, 0);
        step(0, 4'b1000, 4'b0000, 4'b1000, -1, 0);
        step(0, 4'b1000, 4'b1000, 4'b1000,  3, 1);

        // Four overlapping hits on ch3 drive the 2-bit twin into saturation.
        step(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        for (int k = 0; k < 9; k++) begin
            step(0, 4'b1000, (k % 2 == 0) ? 4'b1000 : 4'b0000, 4'b1000,
                 (k >= 2 && k % 2 == 0) ? 3 : -1, k / 2);
        end
        for (int k = 0; k < 3; k++) step(0, 4'b0000, 4'b0000, 4'b0000, -1, 0);
        check("hits_outstanding", 32'(hq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
